// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg: shared widths, fetch defaults and the queue entry layout
package fetch_queue_unit_pkg;
    localparam int WORD = 32;
    localparam int INSTR_LEN = 32;
    localparam int FETCH_PC_STEP = 4;
    localparam int FETCH_Q_DEPTH = 4;
    typedef struct packed {
        logic [WORD-1:0] pc;
        logic [INSTR_LEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: redirect (pc_src, branch_target), decode handshake (out_valid/out_ready, instruction, cur_pc) and status (fetch_pc, q_count)
interface fetch_queue_unit_if import fetch_queue_unit_pkg::*; #(parameter int DEPTH = FETCH_Q_DEPTH) ();
    logic pc_src;
    logic [WORD-1:0] branch_target;
    logic out_ready;
    logic out_valid;
    logic [INSTR_LEN-1:0] instruction;
    logic [WORD-1:0] cur_pc;
    logic [WORD-1:0] fetch_pc;
    logic [$clog2(DEPTH):0] q_count;
    modport master (output pc_src, branch_target, out_ready, input out_valid, instruction, cur_pc, fetch_pc, q_count);
    modport slave (input pc_src, branch_target, out_ready, output out_valid, instruction, cur_pc, fetch_pc, q_count);
endinterface

// File: rtl/fetch_queue_unit_queue.sv
// fetch_queue: DEPTH-entry FIFO with push/pop/flush, head data dout (0 when empty), count, full, empty
module fetch_queue #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    always_ff @(posedge clk)
        if (push) mem[wr] <= din;
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            rd <= rd + AW'(pop);
            wr <= wr + AW'(push);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign dout = empty ? '0 : mem[rd];
endmodule

// File: rtl/instr_mem.sv
// instr_mem: combinational instruction ROM indexed by word address (word in, instr out)
module instr_mem import fetch_queue_unit_pkg::*; #(
    parameter int SIZE = 1024
) (
    input  logic [$clog2(SIZE)-3:0] word,
    output logic [INSTR_LEN-1:0]    instr
);
    assign instr = (INSTR_LEN'(word) << 20) | INSTR_LEN'(32'h13);
endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: PC sequencer + instr_mem read feeding a prefetch queue to decode; clk/reset plain, everything else on bus
module fetch_queue_unit import fetch_queue_unit_pkg::*; #(
    parameter int              SIZE = 1024,
    parameter int              DEPTH = FETCH_Q_DEPTH,
    parameter logic [WORD-1:0] RESET_PC = '0,
    parameter int              PC_STEP = FETCH_PC_STEP
) (
    input logic               clk,
    input logic               reset,
    fetch_queue_unit_if.slave bus
);
    fetch_entry_t head;
    logic [WORD-1:0] fetch_pc;
    logic [INSTR_LEN-1:0] instr;
    logic [$clog2(DEPTH):0] count;
    logic full, empty, push, pop;
    assign pop = !empty && bus.out_ready;
    assign push = !bus.pc_src && (!full || pop);
    instr_mem #(.SIZE(SIZE)) u_mem (
        .word  (fetch_pc[$clog2(SIZE)-1:2]),
        .instr (instr)
    );
    fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (bus.pc_src),
        .din   ({fetch_pc, instr}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk) begin
        if (reset) fetch_pc <= RESET_PC;
        else if (bus.pc_src) fetch_pc <= bus.branch_target & ~WORD'(3);
        else if (push) fetch_pc <= fetch_pc + WORD'(PC_STEP);
    end
    assign bus.out_valid = !empty;
    assign bus.instruction = head.instr;
    assign bus.cur_pc = head.pc;
    assign bus.fetch_pc = fetch_pc;
    assign bus.q_count = count;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed bench for reset, streaming, back-pressure, redirect and PC wrap
module tb_fetch_queue_unit;
    import fetch_queue_unit_pkg::*;
    logic clk = 1'b0;
    logic reset, reset_b;
    logic [31:0] e;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    fetch_queue_unit_if ifa ();
    fetch_queue_unit_if ifb ();
    fetch_queue_unit dut_a (.clk(clk), .reset(reset), .bus(ifa));
    fetch_queue_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));
    function automatic logic [31:0] img(input logic [31:0] a);
        return (((a % 1024) / 4) << 20) | 32'h13;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
    initial begin
        reset = 1; reset_b = 1;
        ifa.pc_src = 0; ifa.branch_target = 0; ifa.out_ready = 0;
        ifb.pc_src = 0; ifb.branch_target = 0; ifb.out_ready = 1;
        step(); step();
        chk("rst_valid", ifa.out_valid, 0);
        chk("rst_count", ifa.q_count, 0);
        chk("rst_instr", ifa.instruction, 0);
        chk("rst_cur_pc", ifa.cur_pc, 0);
        reset = 0; ifa.out_ready = 1;
        chk("rel_fetch_pc", ifa.fetch_pc, 0);
        chk("rel_valid", ifa.out_valid, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("stream_valid", ifa.out_valid, 1);
            chk("stream_pc", ifa.cur_pc, 4 * i);
            chk("stream_instr", ifa.instruction, img(4 * i));
            chk("stream_count", ifa.q_count, 1);
            step();
        end
        reset = 1; ifa.out_ready = 0;
        step();
        reset = 0;
        chk("mid_rst_valid", ifa.out_valid, 0);
        chk("mid_rst_count", ifa.q_count, 0);
        chk("mid_rst_fetch_pc", ifa.fetch_pc, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("bp_count", ifa.q_count, (k < 4) ? k : 4);
        end
        chk("bp_fetch_pc", ifa.fetch_pc, 16);
        chk("bp_head_pc", ifa.cur_pc, 0);
        chk("bp_valid", ifa.out_valid, 1);
        ifa.out_ready = 1;
        for (int j = 0; j < 5; j++) begin
            chk("drain_pc", ifa.cur_pc, 4 * j);
            chk("drain_instr", ifa.instruction, img(4 * j));
            chk("drain_count", ifa.q_count, 4);
            step();
        end
        ifa.out_ready = 0;
        step();
        chk("full_count", ifa.q_count, 4);
        chk("full_fetch_pc", ifa.fetch_pc, 36);
        chk("full_head_pc", ifa.cur_pc, 20);
        ifa.pc_src = 1; ifa.branch_target = 32'h103;
        step();
        ifa.pc_src = 0;
        chk("redir_count", ifa.q_count, 0);
        chk("redir_valid", ifa.out_valid, 0);
        chk("redir_fetch_pc", ifa.fetch_pc, 32'h100);
        step();
        chk("redir_head_valid", ifa.out_valid, 1);
        chk("redir_head_pc", ifa.cur_pc, 32'h100);
        chk("redir_head_instr", ifa.instruction, img(32'h100));
        chk("redir_head_count", ifa.q_count, 1);
        step(); step();
        chk("pre_pop_count", ifa.q_count, 3);
        ifa.pc_src = 1; ifa.branch_target = 32'h200; ifa.out_ready = 1;
        chk("pop_head_pc", ifa.cur_pc, 32'h100);
        step();
        chk("rp_count", ifa.q_count, 0);
        chk("rp_valid", ifa.out_valid, 0);
        chk("rp_fetch_pc", ifa.fetch_pc, 32'h200);
        step();
        chk("empty_count", ifa.q_count, 0);
        chk("empty_cur_pc", ifa.cur_pc, 0);
        chk("empty_instr", ifa.instruction, 0);
        ifa.pc_src = 0;
        step();
        chk("rp_next_pc", ifa.cur_pc, 32'h200);
        chk("rp_next_count", ifa.q_count, 1);
        step();
        chk("rp_after_pc", ifa.cur_pc, 32'h204);
        reset_b = 0;
        chk("wrap_rst_fetch_pc", ifb.fetch_pc, 32'hFFFF_FFF8);
        step();
        for (int k = 0; k < 10; k++) begin
            e = 32'hFFFF_FFF8 + 32'(4 * k);
            chk("wrap_pc", ifb.cur_pc, e);
            chk("wrap_instr", ifb.instruction, img(e));
            chk("wrap_count", ifb.q_count, 1);
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
